// File: rtl/dkong_snd_pkg.sv
// Shared types and widths for the Donkey Kong sound-board ROM arbiter.
package dkong_snd_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} snd_arb_state_t;
    typedef enum logic {REQ_CPU, REQ_WAV} snd_req_t;

    localparam int SND_MEM_AW = 20;
    localparam int SND_CPU_AW = 12;
    localparam int SND_WAV_AW = 19;

    // Memory address = base + zero-extended requester offset, wrapping at 2^20.
    function automatic logic [SND_MEM_AW-1:0] snd_mem_addr(
        input logic [SND_MEM_AW-1:0] base,
        input logic [SND_MEM_AW-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/dkong_rom_tag_cache.sv
// One-entry hit cache: tag, valid bit and data byte for a single ROM requester.
module dkong_rom_tag_cache #(
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic [AW-1:0] i_addr,
    input  logic          i_grant,
    input  logic          i_fill,
    input  logic [7:0]    i_fill_data,
    output logic          o_hit,
    output logic [7:0]    o_data
);

    logic [AW-1:0] r_tag;
    logic [AW-1:0] r_pend_tag;
    logic          r_valid;
    logic          r_flushed;
    logic [7:0]    r_data;

    assign o_hit  = r_valid & ~i_flush & (r_tag == i_addr);
    assign o_data = r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag      <= '0;
            r_pend_tag <= '0;
            r_valid    <= 1'b0;
            r_flushed  <= 1'b0;
            r_data     <= 8'h00;
        end else begin
            // A flush seen while our fetch is in flight must keep that fill untagged.
            if (i_grant) begin
                r_pend_tag <= i_addr;
                r_flushed  <= 1'b0;
            end else if (i_flush) begin
                r_flushed  <= 1'b1;
            end
            if (i_flush)
                r_valid <= 1'b0;
            if (i_fill) begin
                r_tag   <= r_pend_tag;
                r_data  <= i_fill_data;
                r_valid <= ~(r_flushed | i_flush);
            end
        end
    end

endmodule

// File: rtl/dkong_sound_rom_arbiter.sv
// Shares one byte-wide memory port between the 8035 program ROM and the wave ROM,
// with a one-entry cache per requester and alternating priority on tied misses.
module dkong_sound_rom_arbiter
    import dkong_snd_pkg::*;
#(
    parameter logic [19:0] CPU_BASE = 20'h80000,
    parameter logic [19:0] WAV_BASE = 20'h00000
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_FLUSH,
    input  logic        I_CPU_REQ,
    input  logic [11:0] I_CPU_A,
    output logic        O_CPU_ACK,
    output logic [7:0]  O_CPU_DO,
    input  logic        I_WAV_REQ,
    input  logic [18:0] I_WAV_A,
    output logic        O_WAV_ACK,
    output logic [7:0]  O_WAV_DO,
    output logic [19:0] O_MEM_A,
    output logic        O_MEM_RD,
    input  logic [7:0]  I_MEM_DO,
    input  logic        I_MEM_VALID
);

    snd_arb_state_t        r_state;
    snd_req_t              r_grant;
    snd_req_t              r_last_grant;
    logic                  r_cpu_ack;
    logic                  r_wav_ack;
    logic [SND_MEM_AW-1:0] r_mem_a;
    logic                  r_mem_rd;

    logic w_idle;
    logic w_cpu_req, w_wav_req;
    logic w_cpu_hit, w_wav_hit;
    logic w_cpu_hit_go, w_wav_hit_go;
    logic w_cpu_miss, w_wav_miss;
    logic w_grant_cpu, w_grant_wav;
    logic w_fill_cpu, w_fill_wav;
    logic [SND_MEM_AW-1:0] w_cpu_mem_a, w_wav_mem_a;

    assign w_idle = (r_state == IDLE);

    // Masking REQ during its own ACK cycle stops a late-dropping requester being served twice.
    assign w_cpu_req = I_CPU_REQ & ~r_cpu_ack;
    assign w_wav_req = I_WAV_REQ & ~r_wav_ack;

    assign w_cpu_hit_go = w_idle & w_cpu_req & w_cpu_hit;
    assign w_wav_hit_go = w_idle & w_wav_req & w_wav_hit;
    assign w_cpu_miss   = w_idle & w_cpu_req & ~w_cpu_hit;
    assign w_wav_miss   = w_idle & w_wav_req & ~w_wav_hit;

    assign w_grant_cpu = w_cpu_miss & (~w_wav_miss | (r_last_grant == REQ_WAV));
    assign w_grant_wav = w_wav_miss & ~w_grant_cpu;

    assign w_fill_cpu = (r_state == WAIT) & I_MEM_VALID & (r_grant == REQ_CPU);
    assign w_fill_wav = (r_state == WAIT) & I_MEM_VALID & (r_grant == REQ_WAV);

    assign w_cpu_mem_a = snd_mem_addr(CPU_BASE, {{(SND_MEM_AW-SND_CPU_AW){1'b0}}, I_CPU_A});
    assign w_wav_mem_a = snd_mem_addr(WAV_BASE, {{(SND_MEM_AW-SND_WAV_AW){1'b0}}, I_WAV_A});

    dkong_rom_tag_cache #(.AW(SND_CPU_AW)) u_cpu_cache (
        .i_clk       (I_CLK),
        .i_rst       (I_RST),
        .i_flush     (I_FLUSH),
        .i_addr      (I_CPU_A),
        .i_grant     (w_grant_cpu),
        .i_fill      (w_fill_cpu),
        .i_fill_data (I_MEM_DO),
        .o_hit       (w_cpu_hit),
        .o_data      (O_CPU_DO)
    );

    dkong_rom_tag_cache #(.AW(SND_WAV_AW)) u_wav_cache (
        .i_clk       (I_CLK),
        .i_rst       (I_RST),
        .i_flush     (I_FLUSH),
        .i_addr      (I_WAV_A),
        .i_grant     (w_grant_wav),
        .i_fill      (w_fill_wav),
        .i_fill_data (I_MEM_DO),
        .o_hit       (w_wav_hit),
        .o_data      (O_WAV_DO)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_state      <= IDLE;
            r_grant      <= REQ_CPU;
            r_last_grant <= REQ_WAV;
            r_cpu_ack    <= 1'b0;
            r_wav_ack    <= 1'b0;
            r_mem_a      <= '0;
            r_mem_rd     <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_wav_ack <= 1'b0;
            r_mem_rd  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cpu_ack <= w_cpu_hit_go;
                    r_wav_ack <= w_wav_hit_go;
                    if (w_grant_cpu) begin
                        r_mem_a      <= w_cpu_mem_a;
                        r_grant      <= REQ_CPU;
                        r_last_grant <= REQ_CPU;
                        r_mem_rd     <= 1'b1;
                        r_state      <= ISSUE;
                    end else if (w_grant_wav) begin
                        r_mem_a      <= w_wav_mem_a;
                        r_grant      <= REQ_WAV;
                        r_last_grant <= REQ_WAV;
                        r_mem_rd     <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (I_MEM_VALID) begin
                        r_state <= IDLE;
                        if (r_grant == REQ_CPU)
                            r_cpu_ack <= 1'b1;
                        else
                            r_wav_ack <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign O_CPU_ACK = r_cpu_ack;
    assign O_WAV_ACK = r_wav_ack;
    assign O_MEM_A   = r_mem_a;
    assign O_MEM_RD  = r_mem_rd;

endmodule
